// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package wr_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side write signals of the arbiter.
// slave = arbiter, master = requesters plus FIFO write-pointer block.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          wfull;
    logic                          wpush;
    logic [DATA_WIDTH-1:0]         wdata;
    logic [ID_W-1:0]               gnt_id;
    logic                          busy;

    modport slave (
        input  req_valid, req_last, req_data, wfull,
        output req_ready, wpush, wdata, gnt_id, busy
    );

    modport master (
        output req_valid, req_last, req_data, wfull,
        input  req_ready, wpush, wdata, gnt_id, busy
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin search: first set request at or after i_start,
// wrapping at NUM_REQ (which need not be a power of 2).
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_start,
    output logic               o_found,
    output logic [ID_W-1:0]    o_idx
);

    int              w_j;
    logic [ID_W-1:0] w_sel;

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_j     = 0;
        w_sel   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_j = int'(i_start) + k;
            if (w_j >= NUM_REQ) begin
                w_j = w_j - NUM_REQ;
            end
            w_sel = ID_W'(w_j);
            if (i_req[w_sel]) begin
                o_found = 1'b1;
                o_idx   = w_sel;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locking arbiter for one async FIFO write port.
// Optional stall counter output enabled by macro WR_ARB_STALL_CNT_EN.
//   state  | meaning
//   IDLE   | no packet open; grant goes to round-robin candidate
//   LOCKED | multi-beat packet open; only the owner may push
module fifo_wr_arbiter
    import wr_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                   wclk,
    input  logic                   wrst,
`ifdef WR_ARB_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
    fifo_wr_arbiter_if.slave       bus
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    arb_state_t       r_state;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [ID_W-1:0]  r_owner;

    logic             w_cand_found;
    logic [ID_W-1:0]  w_cand_idx;
    logic [ID_W-1:0]  w_gnt_id;
    logic [NUM_REQ-1:0] w_ready;
    logic             w_push;
    logic             w_last;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_picker (
        .i_req   (bus.req_valid),
        .i_start (r_rr_ptr),
        .o_found (w_cand_found),
        .o_idx   (w_cand_idx)
    );

    always_comb begin
        w_gnt_id = (r_state == LOCKED) ? r_owner : w_cand_idx;
        w_ready  = '0;
        if (!wrst && !bus.wfull) begin
            if (r_state == LOCKED) begin
                w_ready[r_owner] = 1'b1;
            end else if (w_cand_found) begin
                w_ready[w_cand_idx] = 1'b1;
            end
        end
        w_push = |(bus.req_valid & w_ready);
        w_last = bus.req_last[w_gnt_id];
    end

    assign bus.req_ready = w_ready;
    assign bus.wpush     = w_push;
    assign bus.wdata     = bus.req_data[w_gnt_id*DATA_WIDTH +: DATA_WIDTH];
    assign bus.gnt_id    = w_gnt_id;
    assign bus.busy      = (r_state == LOCKED);

    // The pointer only moves on a packet's last beat, so fairness is per packet.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_push) begin
                        if (w_last) begin
                            r_rr_ptr <= (w_cand_idx == LAST_ID) ? '0 : w_cand_idx + 1'b1;
                        end else begin
                            r_state <= LOCKED;
                            r_owner <= w_cand_idx;
                        end
                    end
                end
                LOCKED: begin
                    if (w_push && w_last) begin
                        r_state  <= IDLE;
                        r_rr_ptr <= (r_owner == LAST_ID) ? '0 : r_owner + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef WR_ARB_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            r_stall_cnt <= '0;
        end else if (|bus.req_valid && bus.wfull && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench: a 4-requester/32-bit instance and a
// 3-requester/8-bit instance for the non-power-of-2 wrap case.
module tb_fifo_wr_arbiter;

    logic wclk = 1'b0;
    logic wrst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus_a ();
    fifo_wr_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(8))  bus_b ();

`ifdef WR_ARB_STALL_CNT_EN
    logic [15:0] stall_a;
    logic [15:0] stall_b;
`endif

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32)) u_dut_a (
        .wclk      (wclk),
        .wrst      (wrst),
`ifdef WR_ARB_STALL_CNT_EN
        .stall_cnt (stall_a),
`endif
        .bus       (bus_a)
    );

    fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8)) u_dut_b (
        .wclk      (wclk),
        .wrst      (wrst),
`ifdef WR_ARB_STALL_CNT_EN
        .stall_cnt (stall_b),
`endif
        .bus       (bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [31:0] d_a [4];
    logic [7:0]  d_b [3];

    initial begin
        d_a[0] = 32'hA000_0000;
        d_a[1] = 32'hA111_1111;
        d_a[2] = 32'hA222_2222;
        d_a[3] = 32'hA333_3333;
        d_b[0] = 8'h50;
        d_b[1] = 8'h51;
        d_b[2] = 8'h52;

        bus_a.req_valid = 4'b1111;
        bus_a.req_last  = 4'b1111;
        bus_a.req_data  = {d_a[3], d_a[2], d_a[1], d_a[0]};
        bus_a.wfull     = 1'b0;
        bus_b.req_valid = 3'b000;
        bus_b.req_last  = 3'b111;
        bus_b.req_data  = {d_b[2], d_b[1], d_b[0]};
        bus_b.wfull     = 1'b0;

        // Reset held two cycles with every requester valid.
        tick();
        tick();
        settle();
        chk("rst_ready", 32'(bus_a.req_ready), 32'h0);
        chk("rst_wpush", 32'(bus_a.wpush), 32'h0);
        chk("rst_gnt", 32'(bus_a.gnt_id), 32'h0);
        chk("rst_busy", 32'(bus_a.busy), 32'h0);

        // Release: single-beat round-robin 0,1,2,3,0.
        wrst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("rr_gnt", 32'(bus_a.gnt_id), 32'(k % 4));
            chk("rr_ready", 32'(bus_a.req_ready), 32'(1 << (k % 4)));
            chk("rr_wpush", 32'(bus_a.wpush), 32'h1);
            chk("rr_wdata", bus_a.wdata, d_a[k % 4]);
            tick();
        end

        // Packet lock: requester 1 sends 3 beats with a 2-cycle gap, 2 waits.
        bus_a.req_valid = 4'b0110;
        bus_a.req_last  = 4'b0100;
        bus_a.req_data  = {d_a[3], d_a[2], 32'hB000_0001, d_a[0]};
        settle();
        chk("lk_b1_gnt", 32'(bus_a.gnt_id), 32'h1);
        chk("lk_b1_wpush", 32'(bus_a.wpush), 32'h1);
        chk("lk_b1_wdata", bus_a.wdata, 32'hB000_0001);
        chk("lk_b1_busy", 32'(bus_a.busy), 32'h0);
        tick();
        bus_a.req_data = {d_a[3], d_a[2], 32'hB000_0002, d_a[0]};
        settle();
        chk("lk_b2_busy", 32'(bus_a.busy), 32'h1);
        chk("lk_b2_ready", 32'(bus_a.req_ready), 32'b0010);
        chk("lk_b2_wdata", bus_a.wdata, 32'hB000_0002);
        tick();
        bus_a.req_valid = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("lk_gap_busy", 32'(bus_a.busy), 32'h1);
            chk("lk_gap_gnt", 32'(bus_a.gnt_id), 32'h1);
            chk("lk_gap_ready", 32'(bus_a.req_ready), 32'b0010);
            chk("lk_gap_wpush", 32'(bus_a.wpush), 32'h0);
            tick();
        end
        bus_a.req_valid = 4'b0110;
        bus_a.req_last  = 4'b0110;
        bus_a.req_data  = {d_a[3], d_a[2], 32'hB000_0003, d_a[0]};
        settle();
        chk("lk_b3_wpush", 32'(bus_a.wpush), 32'h1);
        chk("lk_b3_wdata", bus_a.wdata, 32'hB000_0003);
        chk("lk_b3_busy", 32'(bus_a.busy), 32'h1);
        tick();
        bus_a.req_valid = 4'b0100;
        settle();
        chk("lk_next_gnt", 32'(bus_a.gnt_id), 32'h2);
        chk("lk_next_ready", 32'(bus_a.req_ready), 32'b0100);
        chk("lk_next_wdata", bus_a.wdata, d_a[2]);
        chk("lk_next_busy", 32'(bus_a.busy), 32'h0);
        tick();

        // Full backpressure on beat 2 of a locked packet from requester 3.
        bus_a.req_valid = 4'b1000;
        bus_a.req_last  = 4'b0000;
        bus_a.req_data  = {32'hC000_0001, d_a[2], d_a[1], d_a[0]};
        settle();
        chk("fb_b1_gnt", 32'(bus_a.gnt_id), 32'h3);
        chk("fb_b1_wpush", 32'(bus_a.wpush), 32'h1);
        tick();
        bus_a.req_data = {32'hC000_0002, d_a[2], d_a[1], d_a[0]};
        bus_a.wfull    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("fb_full_ready", 32'(bus_a.req_ready), 32'h0);
            chk("fb_full_wpush", 32'(bus_a.wpush), 32'h0);
            chk("fb_full_gnt", 32'(bus_a.gnt_id), 32'h3);
            chk("fb_full_busy", 32'(bus_a.busy), 32'h1);
            chk("fb_full_wdata", bus_a.wdata, 32'hC000_0002);
            tick();
        end
        bus_a.wfull = 1'b0;
        settle();
        chk("fb_rel_ready", 32'(bus_a.req_ready), 32'b1000);
        chk("fb_rel_wpush", 32'(bus_a.wpush), 32'h1);
        chk("fb_rel_wdata", bus_a.wdata, 32'hC000_0002);
        tick();
        bus_a.req_last = 4'b1000;
        bus_a.req_data = {32'hC000_0003, d_a[2], d_a[1], d_a[0]};
        settle();
        chk("fb_b3_wpush", 32'(bus_a.wpush), 32'h1);
        tick();
        bus_a.req_valid = 4'b0000;
        settle();
        chk("fb_end_busy", 32'(bus_a.busy), 32'h0);
        chk("fb_end_wpush", 32'(bus_a.wpush), 32'h0);

        // Full while idle with a candidate: no accept.
        bus_a.req_valid = 4'b0001;
        bus_a.req_last  = 4'b0001;
        bus_a.wfull     = 1'b1;
        settle();
        chk("idle_full_ready", 32'(bus_a.req_ready), 32'h0);
        chk("idle_full_gnt", 32'(bus_a.gnt_id), 32'h0);
        bus_a.wfull     = 1'b0;
        bus_a.req_valid = 4'b0000;

        // Non-power-of-2 wrap on the 3-requester instance: move rr_ptr to 2 first.
        bus_b.req_valid = 3'b010;
        settle();
        chk("w3_pre_gnt", 32'(bus_b.gnt_id), 32'h1);
        tick();
        bus_b.req_valid = 3'b101;
        settle();
        chk("w3_g1", 32'(bus_b.gnt_id), 32'h2);
        chk("w3_d1", 32'(bus_b.wdata), 32'(d_b[2]));
        tick();
        settle();
        chk("w3_g2", 32'(bus_b.gnt_id), 32'h0);
        chk("w3_d2", 32'(bus_b.wdata), 32'(d_b[0]));
        chk("w3_r2", 32'(bus_b.req_ready), 32'b001);
        tick();
        settle();
        chk("w3_g3", 32'(bus_b.gnt_id), 32'h2);
        chk("w3_r3", 32'(bus_b.req_ready), 32'b100);
        tick();
        bus_b.req_valid = 3'b000;

`ifdef WR_ARB_STALL_CNT_EN
        wrst = 1'b1;
        tick();
        chk("st_clr", 32'(stall_a), 32'h0);
        wrst = 1'b0;
        bus_a.req_valid = 4'b0001;
        bus_a.wfull     = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("st_three", 32'(stall_a), 32'h3);
        for (int k = 3; k < 70000; k++) tick();
        chk("st_sat", 32'(stall_a), 32'hFFFF);
        tick();
        chk("st_hold", 32'(stall_a), 32'hFFFF);
        wrst = 1'b1;
        tick();
        chk("st_rst", 32'(stall_a), 32'h0);
        wrst = 1'b0;
        bus_a.wfull     = 1'b0;
        bus_a.req_valid = 4'b0000;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
